// File: rtl/fir_coeff_loader_pkg.sv
// Shared constants and state encodings for the FIR coefficient loader.
// Define FIR_COEFF_SYMMETRIC_EN to load half a bank and mirror each write.
package fir_coeff_loader_pkg;

  localparam int unsigned Q15_WIDTH       = 16;
  localparam int unsigned COEFF_WIDTH_DEF = Q15_WIDTH;
  localparam int unsigned NUM_TAPS_DEF    = 33;

  // FLUSH holds the cycle in which the final write sits on the coefficient port.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_MIRROR = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FIN    = 3'd4,
    ST_FLUSH  = 3'd5
  } load_state_e;

  // Number of beats a well-formed bank carries.
  function automatic int unsigned bank_len(input int unsigned num_taps);
`ifdef FIR_COEFF_SYMMETRIC_EN
    return (num_taps + 1) / 2;
`else
    return num_taps;
`endif
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Writer side of the FIR coefficient port: streams one bank into the filter.
// FIR_COEFF_SYMMETRIC_EN: bank carries taps 0..EXP-1, each write is mirrored.
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter int unsigned NUM_TAPS    = NUM_TAPS_DEF,
  parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEF,
  parameter int unsigned IDX_WIDTH   = $clog2(NUM_TAPS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [COEFF_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  output logic                   coeff_wr_en,
  output logic [IDX_WIDTH-1:0]   coeff_idx,
  output logic [COEFF_WIDTH-1:0] coeff_w,
  output logic                   busy,
  output logic                   fir_hold,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned          EXP    = bank_len(NUM_TAPS);
  localparam logic [IDX_WIDTH-1:0] LAST_B = IDX_WIDTH'(EXP - 1);

  load_state_e          state_q;
  load_state_e          state_d;
  load_state_e          after_beat;
  logic [IDX_WIDTH-1:0] b_q;
  logic [IDX_WIDTH-1:0] b_d;
  logic                 hs;
  logic                 mirror_c;
  logic                 tl_sel;
  logic                 len_bad;

  logic                   wr_en_d;
  logic [IDX_WIDTH-1:0]   idx_d;
  logic [COEFF_WIDTH-1:0] w_d;
  logic                   tready_d;
  logic                   busy_d;
  logic                   done_d;
  logic                   err_d;

  assign hs = s_tvalid && s_tready;

`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam logic [IDX_WIDTH-1:0] TOP_IDX = IDX_WIDTH'(NUM_TAPS - 1);

  logic tlast_q;

  // Centre tap of an odd bank maps onto itself and gets no mirror write.
  assign mirror_c = (TOP_IDX - b_q) != b_q;
  assign tl_sel   = (state_q == ST_MIRROR) ? tlast_q : s_tlast;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tlast_q <= 1'b0;
    end else if (state_q == ST_LOAD && hs) begin
      tlast_q <= s_tlast;
    end
  end
`else
  assign mirror_c = 1'b0;
  assign tl_sel   = s_tlast;
`endif

  // Length verdict for the beat being retired (after its mirror, if any).
  assign len_bad    = tl_sel ? (b_q != LAST_B) : (b_q == LAST_B);
  assign after_beat = tl_sel ? ST_FLUSH : ((b_q == LAST_B) ? ST_DRAIN : ST_LOAD);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD:   if (hs) state_d = mirror_c ? ST_MIRROR : after_beat;
`ifdef FIR_COEFF_SYMMETRIC_EN
      ST_MIRROR: state_d = after_beat;
`endif
      ST_DRAIN:  if (hs && s_tlast) state_d = ST_FIN;
      ST_FLUSH:  state_d = ST_FIN;
      ST_FIN:    state_d = start ? ST_LOAD : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and beat counter.
  always_comb begin
    wr_en_d  = 1'b0;
    idx_d    = coeff_idx;
    w_d      = coeff_w;
    err_d    = err;
    b_d      = b_q;
    tready_d = (state_d == ST_LOAD) || (state_d == ST_DRAIN);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_FIN);
    done_d   = (state_d == ST_FIN);
    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          b_d   = '0;
          err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          wr_en_d = 1'b1;
          idx_d   = b_q;
          w_d     = s_tdata;
          if (!mirror_c) begin
            err_d = err | len_bad;
            b_d   = b_q + IDX_WIDTH'(1);
          end
        end
      end
`ifdef FIR_COEFF_SYMMETRIC_EN
      ST_MIRROR: begin
        wr_en_d = 1'b1;
        idx_d   = TOP_IDX - b_q;
        err_d   = err | len_bad;
        b_d     = b_q + IDX_WIDTH'(1);
      end
`endif
      default: begin
      end
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_q         <= '0;
      coeff_wr_en <= 1'b0;
      coeff_idx   <= '0;
      coeff_w     <= '0;
      s_tready    <= 1'b0;
      busy        <= 1'b0;
      fir_hold    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      b_q         <= b_d;
      coeff_wr_en <= wr_en_d;
      coeff_idx   <= idx_d;
      coeff_w     <= w_d;
      s_tready    <= tready_d;
      busy        <= busy_d;
      fir_hold    <= busy_d;
      done        <= done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader with a bank-level reference model.
// Honours FIR_COEFF_SYMMETRIC_EN when defined for the whole build.
module tb_fir_coeff_loader;

  localparam int NT = 5;
  localparam int CW = 16;
  localparam int IW = 3;
`ifdef FIR_COEFF_SYMMETRIC_EN
  localparam int EXP = (NT + 1) / 2;
`else
  localparam int EXP = NT;
`endif
  localparam int BOUND = 40;

  logic          clk      = 1'b0;
  logic          rstn     = 1'b1;
  logic          start    = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast  = 1'b0;
  logic [CW-1:0] s_tdata  = '0;
  logic          s_tready;
  logic          coeff_wr_en;
  logic [IW-1:0] coeff_idx;
  logic [CW-1:0] coeff_w;
  logic          busy;
  logic          fir_hold;
  logic          done;
  logic          err;

  typedef struct { int idx; int w; int cyc; } wr_t;
  typedef struct { int cyc; int err; } done_t;

  wr_t           wr_q[$];
  done_t         done_q[$];
  logic [CW-1:0] beat_q[$];
  int            gap_q[$];
  wr_t           mon_wr;
  done_t         mon_done;
  int            cyc = 0;
  int            last_done_cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  fir_coeff_loader #(.NUM_TAPS(NT), .COEFF_WIDTH(CW), .IDX_WIDTH(IW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .coeff_wr_en(coeff_wr_en),
    .coeff_idx  (coeff_idx),
    .coeff_w    (coeff_w),
    .busy       (busy),
    .fir_hold   (fir_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write and every done pulse is matched against the model queues.
  always @(negedge clk) begin
    if (coeff_wr_en) begin
      chk("write_expected", int'(wr_q.size() > 0), 1);
      if (wr_q.size() > 0) begin
        mon_wr = wr_q.pop_front();
        chk("wr_idx", int'(coeff_idx), mon_wr.idx);
        chk("wr_data", int'(coeff_w), mon_wr.w);
        chk("wr_cycle", cyc, mon_wr.cyc);
      end
    end
    if (done) begin
      chk("done_expected", int'(done_q.size() > 0), 1);
      if (done_q.size() > 0) begin
        mon_done = done_q.pop_front();
        chk("done_cycle", cyc, mon_done.cyc);
        chk("done_err", int'(err), mon_done.err);
        chk("busy_at_done", int'(busy), 0);
        chk("hold_at_done", int'(fir_hold), 0);
      end
    end
  end

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("hold_after_start", int'(fir_hold), 1);
    chk("err_cleared", int'(err), 0);
  endtask

  // Drives the bank in beat_q and predicts writes/done from the bank rules.
  task automatic run_load(input bit early, input int midstart_after,
                          input int reset_after, input bit b2b);
    int n;
    int g;
    int w;
    int hs_cyc;
    int last_wr;
    n = beat_q.size();
    last_wr = 0;
    if (early) begin
      s_tvalid = 1'b1;
      s_tdata  = beat_q[0];
      s_tlast  = (n == 1);
    end
    start_pulse();
    for (int i = 0; i < n; i++) begin
      g = (i < gap_q.size()) ? gap_q[i] : 0;
      if (!(early && i == 0))
        for (int k = 0; k < g; k++) @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = beat_q[i];
      s_tlast  = (i == n - 1);
      w = 0;
      while (!s_tready && w < BOUND) begin
        @(negedge clk);
        w++;
      end
      chk("handshake_wait", int'(w < BOUND), 1);
      hs_cyc = cyc;
      if (i < EXP) begin
        wr_q.push_back(wr_t'{idx: i, w: int'(beat_q[i]), cyc: hs_cyc + 1});
        last_wr = hs_cyc + 1;
`ifdef FIR_COEFF_SYMMETRIC_EN
        if (NT - 1 - i != i) begin
          wr_q.push_back(wr_t'{idx: NT - 1 - i, w: int'(beat_q[i]), cyc: hs_cyc + 2});
          last_wr = hs_cyc + 2;
        end
`endif
      end
      if (i == n - 1) begin
        last_done_cyc = (i < EXP) ? last_wr + 1 : hs_cyc + 1;
        done_q.push_back(done_t'{cyc: last_done_cyc, err: int'(n != EXP)});
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
`ifdef FIR_COEFF_SYMMETRIC_EN
      if (i < EXP && NT - 1 - i != i) chk("tready_low_mirror", int'(s_tready), 0);
`endif
      if (i == midstart_after) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == reset_after) begin
        repeat (3) @(negedge clk);
        chk("err_before_reset", int'(err), int'(i >= EXP - 1));
        chk("writes_before_reset", wr_q.size(), 0);
        rstn = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_hold", int'(fir_hold), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_tready", int'(s_tready), 0);
        chk("rst_wr_en", int'(coeff_wr_en), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        return;
      end
    end
    w = 0;
    if (b2b) begin
      while (cyc != last_done_cyc && w < BOUND) begin
        @(negedge clk);
        w++;
      end
      chk("b2b_wait", int'(w < BOUND), 1);
    end else begin
      while ((done_q.size() > 0 || wr_q.size() > 0) && w < BOUND) begin
        @(negedge clk);
        w++;
      end
      chk("done_wait", int'(w < BOUND), 1);
      repeat (2) @(negedge clk);
      chk("err_sticky", int'(err), int'(n != EXP));
    end
  endtask

  task automatic set_bank(input int n, input int base, input int step);
    beat_q.delete();
    gap_q.delete();
    for (int i = 0; i < n; i++) beat_q.push_back(CW'(base + i * step));
  endtask

  initial begin
    #2;
    rstn     = 1'b0;
    start    = 1'($urandom);
    s_tvalid = 1'($urandom);
    s_tlast  = 1'($urandom);
    s_tdata  = CW'($urandom);
    repeat (3) @(negedge clk);
    chk("reset_tready", int'(s_tready), 0);
    chk("reset_wr_en", int'(coeff_wr_en), 0);
    chk("reset_idx", int'(coeff_idx), 0);
    chk("reset_w", int'(coeff_w), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_hold", int'(fir_hold), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    rstn  = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_tvalid = 1'($urandom);
      s_tdata  = CW'($urandom);
      @(negedge clk);
      chk("idle_tready", int'(s_tready), 0);
      chk("idle_busy", int'(busy), 0);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    // Nominal bank with one idle cycle after the second beat.
    set_bank(5, 16'h0100, 16'h0100);
    gap_q = '{0, 0, 1, 0, 0};
    run_load(1'b0, -1, -1, 1'b0);
    // Short bank, long bank.
    set_bank(3, 16'h1111, 16'h1111);
    run_load(1'b0, -1, -1, 1'b0);
    set_bank(7, 16'h0a01, 16'h0101);
    run_load(1'b0, -1, -1, 1'b0);
    // Ignored mid-load start, then reset after the second beat.
    set_bank(5, 16'h7001, 16'h0011);
    run_load(1'b0, 0, 1, 1'b0);
    // Reset while discarding surplus beats of a long bank.
    set_bank(7, 16'h5000, 16'h0003);
    run_load(1'b0, -1, 5, 1'b0);
    // Load after reset restarts at index 0; next one starts in the done cycle.
    set_bank(5, 16'h0100, 16'h0100);
    run_load(1'b1, -1, -1, 1'b1);
    set_bank(3, 16'ha000, 16'h1000);
    run_load(1'b0, -1, -1, 1'b0);

    for (int r = 0; r < 16; r++) begin
      beat_q.delete();
      gap_q.delete();
      for (int i = 0; i < int'($urandom_range(1, EXP + 3)); i++) begin
        beat_q.push_back(CW'($urandom));
        gap_q.push_back(($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2)));
      end
      run_load(($urandom_range(0, 3) == 0), -1, -1, (r != 15) && ($urandom_range(0, 2) == 0));
    end

    repeat (4) @(negedge clk);
    chk("pending_writes", wr_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
